systolic_operand_feeder: RTL

// Operand-side driver for systolic_array. Buffers one N_SIZE x N_SIZE job (A and B) loaded row by row over a

---
 rtl/systolic_operand_feeder.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/systolic_operand_feeder.sv
// Operand-side driver for a systolic array. Buffers one N_SIZE x N_SIZE job
// (matrices A and B), which arrives one row per beat over a valid/ready port.
// It then streams column k of A and row k of B for N_SIZE consecutive cycles,
// counts the result rows the array returns, and pulses done.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   ld_valid/ld_ready load handshake; ld_a_row/ld_b_row carry row r of A/B
//   matrix_valid_out  high while a k-slice is presented on matrix_a_out/matrix_b_out
//   matrix_a_out      slice i = A[i][k]
//   matrix_b_out      slice j = B[k][j]
//   res_valid         one pulse per result row from the array
//   busy, done        job in flight; one-cycle completion pulse
//   err_unexpected    sticky: res_valid seen outside WAIT
//   err_timeout       sticky: result rows did not arrive within TIMEOUT cycles
module systolic_operand_feeder #(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned N_SIZE    = 3,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [N_SIZE*DATAWIDTH-1:0]   ld_a_row,
  input  logic [N_SIZE*DATAWIDTH-1:0]   ld_b_row,
  output logic                          matrix_valid_out,
  output logic [N_SIZE*DATAWIDTH-1:0]   matrix_a_out,
  output logic [N_SIZE*DATAWIDTH-1:0]   matrix_b_out,
  input  logic                          res_valid,
  output logic                          busy,
  output logic                          done,
  output logic                          err_unexpected,
  output logic                          err_timeout
);

  localparam int unsigned CntW = $clog2(N_SIZE + 1);
  localparam int unsigned TmrW = $clog2(TIMEOUT + 1);
  localparam int unsigned RowW = N_SIZE * DATAWIDTH;

  localparam logic [1:0] StLoad   = 2'd0;
  localparam logic [1:0] StStream = 2'd1;
  localparam logic [1:0] StWait   = 2'd2;

  logic [DATAWIDTH-1:0] a_buf_q [N_SIZE][N_SIZE];
  logic [DATAWIDTH-1:0] b_buf_q [N_SIZE][N_SIZE];

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] row_q, row_d;
  logic [CntW-1:0] beat_q, beat_d;
  logic [CntW-1:0] res_cnt_q, res_cnt_d;
  logic [TmrW-1:0] timer_q, timer_d;

  logic            ld_ready_q, ld_ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            valid_q, valid_d;
  logic [RowW-1:0] a_out_q, a_out_d;
  logic [RowW-1:0] b_out_q, b_out_d;
  logic            err_unexp_q, err_unexp_d;
  logic            err_to_q, err_to_d;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    beat_d    = beat_q;
    res_cnt_d = res_cnt_q;
    timer_d   = timer_q;
    done_d    = 1'b0;
    valid_d   = 1'b0;
    a_out_d   = '0;
    b_out_d   = '0;
    err_to_d  = err_to_q;
    // Result rows are only expected while waiting; anything else is flagged and dropped.
    err_unexp_d = err_unexp_q | (res_valid && (state_q != StWait));

    case (state_q)
      StLoad: begin
        if (ld_valid) begin
          if (row_q == CntW'(N_SIZE - 1)) begin
            row_d   = '0;
            beat_d  = '0;
            state_d = StStream;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      StStream: begin
        valid_d = 1'b1;
        for (int unsigned i = 0; i < N_SIZE; i++) begin
          a_out_d[i*DATAWIDTH +: DATAWIDTH] = a_buf_q[i][beat_q];
          b_out_d[i*DATAWIDTH +: DATAWIDTH] = b_buf_q[beat_q][i];
        end
        if (beat_q == CntW'(N_SIZE - 1)) begin
          state_d   = StWait;
          timer_d   = '0;
          res_cnt_d = '0;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      StWait: begin
        res_cnt_d = res_cnt_q + CntW'(res_valid);
        timer_d   = timer_q + 1'b1;
        // Completion takes priority over a timeout landing on the same edge.
        if (res_cnt_d == CntW'(N_SIZE)) begin
          done_d  = 1'b1;
          state_d = StLoad;
        end else if (timer_d == TmrW'(TIMEOUT)) begin
          err_to_d = 1'b1;
          state_d  = StLoad;
        end
      end
      default: state_d = StLoad;
    endcase

    ld_ready_d = (state_d == StLoad);
    busy_d     = (state_d != StLoad);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StLoad;
      row_q       <= '0;
      beat_q      <= '0;
      res_cnt_q   <= '0;
      timer_q     <= '0;
      ld_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      a_out_q     <= '0;
      b_out_q     <= '0;
      err_unexp_q <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      beat_q      <= beat_d;
      res_cnt_q   <= res_cnt_d;
      timer_q     <= timer_d;
      ld_ready_q  <= ld_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      valid_q     <= valid_d;
      a_out_q     <= a_out_d;
      b_out_q     <= b_out_d;
      err_unexp_q <= err_unexp_d;
      err_to_q    <= err_to_d;
    end
  end

  // Operand buffers carry no reset; a discarded partial load is simply overwritten.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == StLoad) && ld_valid) begin
      for (int unsigned j = 0; j < N_SIZE; j++) begin
        a_buf_q[row_q][j] <= ld_a_row[j*DATAWIDTH +: DATAWIDTH];
        b_buf_q[row_q][j] <= ld_b_row[j*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  assign ld_ready         = ld_ready_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign matrix_valid_out = valid_q;
  assign matrix_a_out     = a_out_q;
  assign matrix_b_out     = b_out_q;
  assign err_unexpected   = err_unexp_q;
  assign err_timeout      = err_to_q;

endmodule
